// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and the
// constant values driven onto the memory write enables and the core reset.
package boot_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CSUM,
    HOLD,
    RUN,
    ERROR
  } boot_state_t;

  // Both byte lanes written together: the loader only ever writes whole words.
  localparam logic [1:0] WE_WORD     = 2'b11;
  // Level of cpu_rst that keeps the risc16b core in reset.
  localparam logic       RST_VAL_CPU = 1'b1;

endpackage

// File: rtl/boot_loader.sv
// boot_loader: brings up the risc16b core. Holds the core in reset, takes a
// program image from the host byte link (length hi/lo, big-endian words,
// XOR checksum), writes each word into program memory through its second
// write port, checks the checksum and then releases the core reset after a
// short hold.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   start     one-cycle pulse; starts a load from IDLE, RUN or ERROR
//   rx_data   host byte
//   rx_valid  rx_data valid
//   rx_ready  loader accepts a byte this cycle (decoded from state)
//   mem_addr  byte address of the word being written (always even)
//   mem_dout  write data, first byte of the word in [15:8]
//   mem_we    byte-lane write enables, 2'b11 for one cycle per word
//   cpu_rst   reset to the risc16b core
//   busy      load in progress
//   done      image loaded and core running
//   err       length or checksum error
module boot_loader #(
  parameter int MAX_WORDS = 32768,
  parameter int RST_HOLD  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_dout,
  output logic [1:0]  mem_we,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic        err
);
  import boot_pkg::*;

  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  boot_state_t state, state_n;
  logic        xfer;
  logic        enter_load;
  logic [15:0] len_word;
  logic [7:0]  len_hi;
  logic [7:0]  data_hi;
  logic [15:0] word_cnt;
  logic [7:0]  hold_cnt;
  logic [7:0]  acc;

  assign xfer     = rx_valid & rx_ready;
  assign len_word = {len_hi, rx_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    rx_ready = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = LEN_HI;
      LEN_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          if ({1'b0, len_word} > MAX_LEN) state_n = ERROR;
          else if (len_word == 16'd0)     state_n = CSUM;
          else                            state_n = DATA_HI;
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = WRITE;
      end
      // word_cnt still holds the pre-decrement value here
      WRITE: state_n = (word_cnt == 16'd1) ? CSUM : DATA_HI;
      CSUM: begin
        rx_ready = 1'b1;
        if (rx_valid) state_n = (rx_data == acc) ? HOLD : ERROR;
      end
      // hold_cnt is loaded with RST_HOLD on entry, so HOLD lasts RST_HOLD cycles
      HOLD:  if (hold_cnt == 8'd1) state_n = RUN;
      RUN:   if (start) state_n = LEN_HI;
      ERROR: if (start) state_n = LEN_HI;
      default: state_n = IDLE;
    endcase
  end

  assign enter_load = (state_n == LEN_HI) && (state != LEN_HI);

  // Registered outputs, address and checksum: cleared by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr <= 16'h0000;
      mem_dout <= 16'h0000;
      mem_we   <= 2'b00;
      cpu_rst  <= RST_VAL_CPU;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      acc      <= 8'h00;
    end else begin
      mem_we <= 2'b00;
      if (enter_load) begin
        mem_addr <= 16'h0000;
        acc      <= 8'h00;
      end
      // The checksum byte itself is compared, never accumulated
      if (xfer && state != CSUM) acc <= acc ^ rx_data;
      if (xfer && state == DATA_LO) begin
        mem_dout <= {data_hi, rx_data};
        mem_we   <= WE_WORD;
      end
      if (state == WRITE) mem_addr <= mem_addr + 16'd2;
      busy    <= state_n inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CSUM, HOLD};
      done    <= (state_n == RUN);
      err     <= (state_n == ERROR);
      cpu_rst <= (state_n == RUN) ? ~RST_VAL_CPU : RST_VAL_CPU;
    end
  end

  // Load datapath: only meaningful after being loaded within a transfer
  always_ff @(posedge clk) begin
    if (xfer && state == LEN_HI)  len_hi   <= rx_data;
    if (xfer && state == LEN_LO)  word_cnt <= len_word;
    if (xfer && state == DATA_HI) data_hi  <= rx_data;
    if (state == WRITE)           word_cnt <= word_cnt - 16'd1;
    if (xfer && state == CSUM)    hold_cnt <= 8'(RST_HOLD);
    else if (state == HOLD)       hold_cnt <= hold_cnt - 8'd1;
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

  localparam int MAX_WORDS = 32768;
  localparam int RST_HOLD  = 4;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    string      nm;
    logic [7:0] by[8];
    int         n;
    int         gap;
    bit         exp_err;
    int         exp_nw;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout;
  logic [1:0]  mem_we;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;
  logic [33:0] wr_q[$];
  int ready_viol = 0;

  boot_loader #(.MAX_WORDS(MAX_WORDS), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_we(mem_we),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every cycle with any write enable, and watch for rx_ready during a write
  always @(negedge clk) begin
    if (mem_we !== 2'b00) wr_q.push_back({mem_we, mem_addr, mem_dout});
    if (mem_we === 2'b11 && rx_ready !== 1'b0) ready_viol++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1; returns just after the transfer edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      n++;
      if (n > 40) begin
        chk("byte accept timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  task automatic run_case(input string nm, input bq_t b, input int maxgap,
                          input bit exp_err, input int exp_nw);
    int len, nsend, nchk, k;
    wr_q.delete();
    ready_viol = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, " busy after start"}, 64'(busy), 64'd1);
    chk({nm, " err after start"}, 64'(err), 64'd0);
    chk({nm, " done after start"}, 64'(done), 64'd0);
    chk({nm, " cpu_rst after start"}, 64'(cpu_rst), 64'd1);
    len   = int'({b[0], b[1]});
    nsend = (len > MAX_WORDS) ? 2 : 3 + 2 * len;
    for (int i = 0; i < nsend; i++) send_byte(b[i], $urandom_range(maxgap, 0));
    rx_valid = 1'b0;
    if (exp_err) begin
      chk({nm, " err"}, 64'(err), 64'd1);
      chk({nm, " done"}, 64'(done), 64'd0);
      chk({nm, " cpu_rst held"}, 64'(cpu_rst), 64'd1);
      chk({nm, " busy"}, 64'(busy), 64'd0);
      chk({nm, " rx_ready"}, 64'(rx_ready), 64'd0);
    end else begin
      k = 0;
      while (cpu_rst === 1'b1 && k < 20) begin
        @(posedge clk); #1;
        k++;
      end
      chk({nm, " cpu_rst release delay"}, 64'(k), 64'(RST_HOLD));
      chk({nm, " done"}, 64'(done), 64'd1);
      chk({nm, " err"}, 64'(err), 64'd0);
      chk({nm, " busy"}, 64'(busy), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    chk({nm, " write count"}, 64'(wr_q.size()), 64'(exp_nw));
    nchk = (wr_q.size() < exp_nw) ? wr_q.size() : exp_nw;
    for (int i = 0; i < nchk; i++)
      chk({nm, " write word"}, 64'(wr_q[i]),
          64'({2'b11, 16'(2 * i), b[2 + 2 * i], b[3 + 2 * i]}));
    chk({nm, " rx_ready during write"}, 64'(ready_viol), 64'd0);
  endtask

  initial begin
    vec_t vt[6];
    bq_t  bq;
    int   len, oversize, badcs;
    logic [7:0] cs;

    vt[0] = '{"normal",   '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00}, 7, 0, 1'b0, 2};
    vt[1] = '{"zero_len", '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 1'b0, 0};
    vt[2] = '{"bad_csum", '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43, 8'h00}, 7, 0, 1'b1, 2};
    vt[3] = '{"oversize", '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 0, 1'b1, 0};
    vt[4] = '{"gaps",     '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42, 8'h00}, 7, 5, 1'b0, 2};
    vt[5] = '{"zero_bad", '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3, 2, 1'b1, 0};

    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    #1;
    chk("reset cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reset rx_ready", 64'(rx_ready), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_addr", 64'(mem_addr), 64'd0);
    chk("reset mem_dout", 64'(mem_dout), 64'd0);
    chk("reset flags", 64'({busy, done, err}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle rx_ready", 64'(rx_ready), 64'd0);

    for (int i = 0; i < 6; i++) begin
      bq.delete();
      for (int j = 0; j < vt[i].n; j++) bq.push_back(vt[i].by[j]);
      run_case(vt[i].nm, bq, vt[i].gap, vt[i].exp_err, vt[i].exp_nw);
    end

    // Randomized images checked against the image-format model
    for (int t = 0; t < 25; t++) begin
      bq.delete();
      oversize = ($urandom_range(9, 0) == 0);
      len = oversize ? MAX_WORDS + 1 + $urandom_range(500, 0)
                     : (($urandom_range(5, 0) == 0) ? 0 : $urandom_range(6, 1));
      bq.push_back(8'(len >> 8));
      bq.push_back(8'(len));
      badcs = 0;
      if (!oversize) begin
        for (int j = 0; j < 2 * len; j++) bq.push_back(8'($urandom));
        cs = 8'h00;
        foreach (bq[j]) cs ^= bq[j];
        badcs = ($urandom_range(3, 0) == 0);
        bq.push_back(badcs ? cs ^ 8'($urandom_range(255, 1)) : cs);
      end
      run_case("random", bq, 3, (oversize || badcs), oversize ? 0 : len);
    end

    // Asynchronous reset while in DATA_LO of the second word
    wr_q.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'hAB, 0);
    rx_data = 8'hCD;
    rx_valid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("async rst cpu_rst", 64'(cpu_rst), 64'd1);
    chk("async rst mem_we", 64'(mem_we), 64'd0);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst rx_ready", 64'(rx_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    chk("async rst writes", 64'(wr_q.size()), 64'd1);
    @(posedge clk); #1;
    chk("after rst idle rx_ready", 64'(rx_ready), 64'd0);
    chk("after rst flags", 64'({cpu_rst, busy, done, err}), 64'b1000);
    bq.delete();
    for (int j = 0; j < 7; j++) bq.push_back(vt[0].by[j]);
    run_case("reload", bq, 1, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
